// File: rtl/dmem_bridge_if.sv
// CPU-side request/response and RAM-side port bundle for dmem_bridge.
interface dmem_bridge_if #(
    parameter int unsigned ADDR_W = 12
);
    logic              cpu_req;
    logic              cpu_we;
    logic [31:0]       cpu_addr;
    logic [31:0]       cpu_wdata;
    logic [2:0]        cpu_dmtype;
    logic [31:0]       cpu_rdata;
    logic              cpu_ready;
    logic              cpu_err;
    logic              ram_en;
    logic              ram_we;
    logic [3:0]        ram_be;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_dmtype, ram_rdata,
        output cpu_rdata, cpu_ready, cpu_err, ram_en, ram_we, ram_be, ram_addr, ram_wdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_dmtype, ram_rdata,
        input  cpu_rdata, cpu_ready, cpu_err, ram_en, ram_we, ram_be, ram_addr, ram_wdata
    );
endinterface

// File: rtl/dmem_bridge.sv
// Load/store bridge from the CPU MEM stage to a word-wide single-port RAM.
// Define DMEM_BYTE_WE_EN when the RAM honours byte enables (sub-word stores skip read-modify-write).
module dmem_bridge #(
    parameter int unsigned ADDR_W = 12
) (
    input  logic         clk,
    input  logic         rst,
    dmem_bridge_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RD    = 3'd1,
        S_RWAIT = 3'd2,
        S_MRG   = 3'd3,
        S_WR    = 3'd4,
        S_RESP  = 3'd5
    } state_t;

    localparam logic [2:0] DT_W  = 3'd0;
    localparam logic [2:0] DT_H  = 3'd1;
    localparam logic [2:0] DT_HU = 3'd2;
    localparam logic [2:0] DT_B  = 3'd3;
    localparam logic [2:0] DT_BU = 3'd4;

    state_t            r_state;
    logic              r_we;
    logic [1:0]        r_lane;
    logic [2:0]        r_dmtype;
    logic [31:0]       r_wdata;
    logic [31:0]       r_buf;
    logic [31:0]       r_rdata;
    logic              r_ready;
    logic              r_err;
    logic              r_ram_en;
    logic              r_ram_we;
    logic [3:0]        r_ram_be;
    logic [ADDR_W-1:0] r_ram_addr;
    logic [31:0]       r_ram_wdata;

    logic              w_bad;
    logic              w_word;
    logic              w_half;
    logic              w_unused;

    // Little-endian lane extraction with sign/zero extension.
    function automatic logic [31:0] fmt_load(input logic [31:0] w, input logic [1:0] lane,
                                             input logic [2:0] dt);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] f;
        b = w[{lane, 3'b000} +: 8];
        h = lane[1] ? w[31:16] : w[15:0];
        case (dt)
            DT_H:    f = {{16{h[15]}}, h};
            DT_HU:   f = {16'h0000, h};
            DT_B:    f = {{24{b[7]}}, b};
            DT_BU:   f = {24'h000000, b};
            default: f = w;
        endcase
        return f;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] w, input logic [31:0] d,
                                          input logic [1:0] lane, input logic [2:0] dt);
        logic [31:0] m;
        m = w;
        if (dt == DT_H || dt == DT_HU) begin
            if (lane[1]) m[31:16] = d[15:0];
            else         m[15:0]  = d[15:0];
        end else begin
            m[{lane, 3'b000} +: 8] = d[7:0];
        end
        return m;
    endfunction

    assign w_word   = (bus.cpu_dmtype == DT_W);
    assign w_half   = (bus.cpu_dmtype == DT_H) || (bus.cpu_dmtype == DT_HU);
    assign w_unused = ^{bus.cpu_addr[31:ADDR_W+2]};

    // Illegal type or misaligned address for the requested size.
    always_comb begin
        w_bad = 1'b0;
        case (bus.cpu_dmtype)
            DT_W:        w_bad = |bus.cpu_addr[1:0];
            DT_H, DT_HU: w_bad = bus.cpu_addr[0];
            DT_B, DT_BU: w_bad = 1'b0;
            default:     w_bad = 1'b1;
        endcase
    end

`ifdef DMEM_BYTE_WE_EN
    logic [3:0]  w_be_sub;
    logic [31:0] w_wrep;
    assign w_be_sub = w_half ? (4'b0011 << {bus.cpu_addr[1], 1'b0})
                             : (4'b0001 << bus.cpu_addr[1:0]);
    assign w_wrep   = w_half ? {2{bus.cpu_wdata[15:0]}} : {4{bus.cpu_wdata[7:0]}};
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_we        <= 1'b0;
            r_lane      <= 2'd0;
            r_dmtype    <= 3'd0;
            r_wdata     <= 32'd0;
            r_buf       <= 32'd0;
            r_rdata     <= 32'd0;
            r_ready     <= 1'b0;
            r_err       <= 1'b0;
            r_ram_en    <= 1'b0;
            r_ram_we    <= 1'b0;
            r_ram_be    <= 4'd0;
            r_ram_addr  <= '0;
            r_ram_wdata <= 32'd0;
        end else begin
            r_ready  <= 1'b0;
            r_err    <= 1'b0;
            r_ram_en <= 1'b0;
            r_ram_we <= 1'b0;
            r_ram_be <= 4'd0;
            case (r_state)
                S_IDLE: begin
                    if (bus.cpu_req) begin
                        r_we       <= bus.cpu_we;
                        r_lane     <= bus.cpu_addr[1:0];
                        r_dmtype   <= bus.cpu_dmtype;
                        r_wdata    <= bus.cpu_wdata;
                        r_ram_addr <= bus.cpu_addr[ADDR_W+1:2];
                        if (w_bad) begin
                            r_state <= S_RESP;
                            r_ready <= 1'b1;
                            r_err   <= 1'b1;
                        end else if (!bus.cpu_we) begin
                            r_state  <= S_RD;
                            r_ram_en <= 1'b1;
                        end else if (w_word) begin
                            r_state     <= S_WR;
                            r_ram_en    <= 1'b1;
                            r_ram_we    <= 1'b1;
                            r_ram_be    <= 4'hF;
                            r_ram_wdata <= bus.cpu_wdata;
                        end else begin
`ifdef DMEM_BYTE_WE_EN
                            r_state     <= S_WR;
                            r_ram_en    <= 1'b1;
                            r_ram_we    <= 1'b1;
                            r_ram_be    <= w_be_sub;
                            r_ram_wdata <= w_wrep;
`else
                            r_state  <= S_RD;
                            r_ram_en <= 1'b1;
`endif
                        end
                    end
                end
                S_RD: r_state <= S_RWAIT;
                S_RWAIT: begin
                    if (r_we) begin
                        r_buf   <= bus.ram_rdata;
                        r_state <= S_MRG;
                    end else begin
                        r_rdata <= fmt_load(bus.ram_rdata, r_lane, r_dmtype);
                        r_ready <= 1'b1;
                        r_state <= S_RESP;
                    end
                end
                S_MRG: begin
                    r_ram_en    <= 1'b1;
                    r_ram_we    <= 1'b1;
                    r_ram_be    <= 4'hF;
                    r_ram_wdata <= merge(r_buf, r_wdata, r_lane, r_dmtype);
                    r_state     <= S_WR;
                end
                S_WR: begin
                    r_ready <= 1'b1;
                    r_state <= S_RESP;
                end
                S_RESP:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.cpu_rdata = r_rdata;
    assign bus.cpu_ready = r_ready;
    assign bus.cpu_err   = r_err;
    assign bus.ram_en    = r_ram_en;
    assign bus.ram_we    = r_ram_we;
    assign bus.ram_be    = r_ram_be;
    assign bus.ram_addr  = r_ram_addr;
    assign bus.ram_wdata = r_ram_wdata;

endmodule

// File: tb/tb_dmem_bridge.sv
// Self-checking bench for dmem_bridge: directed table, reset-abort sequence, random traffic vs byte-level model.
module tb_dmem_bridge;

`ifdef DMEM_BYTE_WE_EN
    localparam int SUB_LAT = 2;
    localparam int RST_AT  = 1;
`else
    localparam int SUB_LAT = 5;
    localparam int RST_AT  = 3;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    dmem_bridge_if #(.ADDR_W(12)) bus ();
    dmem_bridge #(.ADDR_W(12)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_vec = 0;
    int n_bad = 0;

    // Bench-side RAM with byte enables, plus a preload port.
    logic [31:0] ram [0:4095];
    logic        pl_en   = 1'b0;
    logic [11:0] pl_addr = '0;
    logic [31:0] pl_data = '0;
    always @(posedge clk) begin
        if (pl_en) begin
            ram[pl_addr] <= pl_data;
        end else if (bus.ram_en) begin
            if (bus.ram_we) begin
                for (int i = 0; i < 4; i++)
                    if (bus.ram_be[i]) ram[bus.ram_addr][8*i +: 8] <= bus.ram_wdata[8*i +: 8];
            end else begin
                bus.ram_rdata <= ram[bus.ram_addr];
            end
        end
    end

    // Reference: byte array covering bytes 0x40..0x5F, plus the last load result.
    logic [7:0]  ref_b [0:31];
    logic [31:0] m_hold = 32'd0;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [2:0]  dt;
        logic [31:0] e_rd;
        logic        e_err;
        int          e_lat;
    } vec_t;
    vec_t tbl [$];

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic preload(input int w, input logic [31:0] d);
        for (int i = 0; i < 4; i++) ref_b[4*w+i] = d[8*i +: 8];
        @(negedge clk);
        pl_addr = 12'(16 + w);
        pl_data = d;
        pl_en   = 1'b1;
        @(negedge clk);
        pl_en   = 1'b0;
    endtask

    task automatic model(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [2:0] dt, output logic [31:0] e_rd, output logic e_err,
                         output int e_lat);
        int     size;
        bit     sgn;
        int     off;
        longint v;
        case (dt)
            3'd0:    begin size = 4; sgn = 1'b0; end
            3'd1:    begin size = 2; sgn = 1'b1; end
            3'd2:    begin size = 2; sgn = 1'b0; end
            3'd3:    begin size = 1; sgn = 1'b1; end
            3'd4:    begin size = 1; sgn = 1'b0; end
            default: begin size = 0; sgn = 1'b0; end
        endcase
        off   = int'(addr[13:0]) - 64;
        e_err = (size == 0);
        if (!e_err) e_err = (int'(addr[1:0]) % size) != 0;
        if (e_err) begin
            e_lat = 1;
        end else if (!we) begin
            v = 0;
            for (int i = 0; i < size; i++) v += longint'(ref_b[off+i]) << (8*i);
            if (sgn && v >= (longint'(1) << (8*size-1))) v -= longint'(1) << (8*size);
            m_hold = 32'(v);
            e_lat  = 3;
        end else begin
            for (int i = 0; i < size; i++) ref_b[off+i] = 8'(wd >> (8*i));
            e_lat = (size == 4) ? 2 : SUB_LAT;
        end
        e_rd = m_hold;
    endtask

    task automatic run(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [2:0] dt, output logic [31:0] rd, output logic er,
                       output int lat, output logic en_seen);
        @(negedge clk);
        bus.cpu_req    = 1'b1;
        bus.cpu_we     = we;
        bus.cpu_addr   = addr;
        bus.cpu_wdata  = wd;
        bus.cpu_dmtype = dt;
        lat     = 0;
        er      = 1'b0;
        en_seen = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            en_seen |= bus.ram_en;
            if (bus.cpu_ready) begin
                lat = c;
                er  = bus.cpu_err;
                break;
            end
        end
        bus.cpu_req = 1'b0;
        rd = bus.cpu_rdata;
        @(negedge clk);
        check("ready_single_cycle", 32'(bus.cpu_ready), 32'd0);
    endtask

    task automatic check_outputs_zero(input string nm);
        check({nm, "_rdata"}, bus.cpu_rdata, 32'd0);
        check({nm, "_wdata"}, bus.ram_wdata, 32'd0);
        check({nm, "_ctl"}, 32'({bus.cpu_ready, bus.cpu_err, bus.ram_en, bus.ram_we,
                                 bus.ram_be, bus.ram_addr}), 32'd0);
    endtask

    initial begin
        logic [31:0] rd, e_rd, addr, wd;
        logic        er, e_err, en_seen, we;
        logic [2:0]  dt;
        int          lat, e_lat, r;

        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0;
        bus.cpu_wdata = '0; bus.cpu_dmtype = '0;
        for (int i = 0; i < 32; i++) ref_b[i] = 8'd0;

        preload(0, 32'h8899AABB);
        for (int w = 1; w < 8; w++) preload(w, $urandom);
        check_outputs_zero("reset");
        @(negedge clk);
        rst = 1'b1;

        tbl.push_back('{1'b0, 32'h41, 32'h0,        3'd3, 32'hFFFFFFAA, 1'b0, 3});
        tbl.push_back('{1'b0, 32'h43, 32'h0,        3'd4, 32'h00000088, 1'b0, 3});
        tbl.push_back('{1'b0, 32'h42, 32'h0,        3'd1, 32'hFFFF8899, 1'b0, 3});
        tbl.push_back('{1'b0, 32'h40, 32'h0,        3'd2, 32'h0000AABB, 1'b0, 3});
        tbl.push_back('{1'b1, 32'h41, 32'h12345677, 3'd3, 32'h0000AABB, 1'b0, SUB_LAT});
        tbl.push_back('{1'b0, 32'h40, 32'h0,        3'd0, 32'h889977BB, 1'b0, 3});
        tbl.push_back('{1'b1, 32'h42, 32'h0000CAFE, 3'd1, 32'h889977BB, 1'b0, SUB_LAT});
        tbl.push_back('{1'b0, 32'h40, 32'h0,        3'd0, 32'hCAFE77BB, 1'b0, 3});
        tbl.push_back('{1'b0, 32'h42, 32'h0,        3'd0, 32'hCAFE77BB, 1'b1, 1});
        tbl.push_back('{1'b0, 32'h40, 32'h0,        3'd7, 32'hCAFE77BB, 1'b1, 1});
        tbl.push_back('{1'b0, 32'h41, 32'h0,        3'd1, 32'hCAFE77BB, 1'b1, 1});
        tbl.push_back('{1'b1, 32'h44, 32'hDEADBEEF, 3'd0, 32'hCAFE77BB, 1'b0, 2});
        tbl.push_back('{1'b0, 32'h44, 32'h0,        3'd0, 32'hDEADBEEF, 1'b0, 3});
        tbl.push_back('{1'b0, 32'h47, 32'h0,        3'd3, 32'hFFFFFFDE, 1'b0, 3});
        tbl.push_back('{1'b0, 32'h46, 32'h0,        3'd2, 32'h0000DEAD, 1'b0, 3});
        tbl.push_back('{1'b1, 32'h42, 32'h11111111, 3'd0, 32'h0000DEAD, 1'b1, 1});
        tbl.push_back('{1'b0, 32'hABCD0040, 32'h0,  3'd0, 32'hCAFE77BB, 1'b0, 3});

        foreach (tbl[k]) begin
            run(tbl[k].we, tbl[k].addr, tbl[k].wd, tbl[k].dt, rd, er, lat, en_seen);
            model(tbl[k].we, tbl[k].addr, tbl[k].wd, tbl[k].dt, e_rd, e_err, e_lat);
            check($sformatf("vec%0d_rdata", k), rd, tbl[k].e_rd);
            check($sformatf("vec%0d_err", k), 32'(er), 32'(tbl[k].e_err));
            check($sformatf("vec%0d_latency", k), 32'(lat), 32'(tbl[k].e_lat));
            if (tbl[k].e_err) check($sformatf("vec%0d_no_ram", k), 32'(en_seen), 32'd0);
        end

        // Reset in the middle of a sub-word store must leave the RAM word untouched.
        preload(0, 32'h8899AABB);
        @(negedge clk);
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 32'h40;
        bus.cpu_wdata = 32'h00000011; bus.cpu_dmtype = 3'd3;
        for (int c = 1; c <= RST_AT; c++) @(negedge clk);
        rst = 1'b0;
        #1;
        check_outputs_zero("abort");
        bus.cpu_req = 1'b0;
        m_hold = 32'd0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_ram_word", ram[16], 32'h8899AABB);
        run(1'b0, 32'h40, 32'h0, 3'd0, rd, er, lat, en_seen);
        check("abort_lw_rdata", rd, 32'h8899AABB);
        check("abort_lw_latency", 32'(lat), 32'd3);
        check("abort_lw_err", 32'(er), 32'd0);
        model(1'b0, 32'h40, 32'h0, 3'd0, e_rd, e_err, e_lat);

        // Random traffic confined to words 0x10..0x17, with junk in the ignored upper address bits.
        for (int n = 0; n < 200; n++) begin
            r    = $urandom_range(0, 9);
            dt   = (r == 9) ? 3'(5 + $urandom_range(0, 2)) : 3'(r % 5);
            we   = 1'($urandom_range(0, 1));
            wd   = $urandom;
            addr = {18'($urandom), 12'(16 + $urandom_range(0, 7)), 2'($urandom_range(0, 3))};
            run(we, addr, wd, dt, rd, er, lat, en_seen);
            model(we, addr, wd, dt, e_rd, e_err, e_lat);
            check($sformatf("rnd%0d_rdata", n), rd, e_rd);
            check($sformatf("rnd%0d_err", n), 32'(er), 32'(e_err));
            check($sformatf("rnd%0d_latency", n), 32'(lat), 32'(e_lat));
            if (e_err) check($sformatf("rnd%0d_no_ram", n), 32'(en_seen), 32'd0);
        end

        for (int w = 0; w < 8; w++)
            check($sformatf("ram_word_%0d", w), ram[16+w],
                  {ref_b[4*w+3], ref_b[4*w+2], ref_b[4*w+1], ref_b[4*w]});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
